mips_multicycle_ctrl: RTL and testbench

Multicycle control unit for the MIPS datapath. Each cycle it decodes the current instruction's opcode/funct and its own state register, and drives the ALU control interface (`select_aluPerformance`, `select_anotherAluSource`) plus the datapath enables. It closes the loop on `alu_zero` for branches and stalls on memory through a ready handshake. It sits between the instruction register and the combinational `alu`, register file and memory ports.

---
 rtl/mips_multicycle_ctrl.sv | 139 +++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM driving ALU controls, datapath enables and a retired-instruction counter.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [1:0]       select_aluPerformance,
  output logic             select_anotherAluSource,
  output logic             ext_op,
  output logic             ir_write,
  output logic             pc_en,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
    WB_ALU, WB_MEM, BRANCH, JUMP, ILLEGAL
  } state_t;

  state_t state, nextState;

  logic isRType, isAddu, isSubu, isOri, isLui, isLw, isSw, isBeq, isJ, retire;
  logic [1:0] aluOp;

  assign isRType = opcode == 6'b000000;
  assign isAddu  = isRType && funct == 6'b100001;
  assign isSubu  = isRType && funct == 6'b100011;
  assign isOri   = opcode == 6'b001101;
  assign isLui   = opcode == 6'b001111;
  assign isLw    = opcode == 6'b100011;
  assign isSw    = opcode == 6'b101011;
  assign isBeq   = opcode == 6'b000100;
  assign isJ     = opcode == 6'b000010;

  // Shared by EXEC_* and WB_ALU so write-back sees the same ALU result.
  assign aluOp = isRType ? (isSubu ? 2'b10 : 2'b00) : (isLui ? 2'b11 : 2'b01);

  assign retire = state == WB_ALU || state == WB_MEM || state == BRANCH ||
                  state == JUMP || (state == MEM_WR && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FETCH;
      retired_count <= '0;
    end else begin
      state         <= nextState;
      retired_count <= retire ? retired_count + 1'b1 : retired_count;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:    nextState = mem_ready ? DECODE : FETCH;
      DECODE:   nextState = (isAddu || isSubu) ? EXEC_R :
                            (isOri || isLui)   ? EXEC_I :
                            (isLw || isSw)     ? MEM_ADDR :
                            isBeq              ? BRANCH :
                            isJ                ? JUMP : ILLEGAL;
      EXEC_R:   nextState = WB_ALU;
      EXEC_I:   nextState = WB_ALU;
      MEM_ADDR: nextState = isLw ? MEM_RD : MEM_WR;
      MEM_RD:   nextState = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:   nextState = mem_ready ? FETCH : MEM_WR;
      WB_ALU:   nextState = FETCH;
      WB_MEM:   nextState = FETCH;
      BRANCH:   nextState = FETCH;
      JUMP:     nextState = FETCH;
      default:  nextState = ILLEGAL;
    endcase
  end

  // Outputs are forced quiet while reset is held so nothing is written.
  always_comb begin
    select_aluPerformance   = 2'b00;
    select_anotherAluSource = 1'b0;
    ext_op                  = 1'b0;
    ir_write                = 1'b0;
    pc_en                   = 1'b0;
    mem_read                = 1'b0;
    mem_write               = 1'b0;
    reg_write               = 1'b0;
    reg_dst                 = 1'b0;
    mem_to_reg              = 1'b0;
    pc_src                  = 2'b00;
    illegal                 = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_en    = mem_ready;
        end
        EXEC_R, EXEC_I: begin
          select_aluPerformance   = aluOp;
          select_anotherAluSource = !isRType;
        end
        WB_ALU: begin
          select_aluPerformance   = aluOp;
          select_anotherAluSource = !isRType;
          reg_write               = 1'b1;
          reg_dst                 = isRType;
        end
        MEM_ADDR, MEM_RD, MEM_WR: begin
          select_anotherAluSource = 1'b1;
          ext_op                  = 1'b1;
          mem_read                = state == MEM_RD;
          mem_write               = state == MEM_WR;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        BRANCH: begin
          select_aluPerformance = 2'b10;
          ext_op                = 1'b1;
          pc_src                = 2'b01;
          pc_en                 = alu_zero;
        end
        JUMP: begin
          pc_src = 2'b10;
          pc_en  = 1'b1;
        end
        ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: randomized bench comparing per-cycle outputs against an instruction-level expected-trace model.
module tb_mips_multicycle_ctrl;
  typedef logic [13:0] vec_t;

  localparam vec_t SUB = 14'h2000, OR_ = 14'h1000, LUI = 14'h3000, SRC = 14'h0800;
  localparam vec_t EXT = 14'h0400, IRW = 14'h0200, PCE = 14'h0100, MR  = 14'h0080;
  localparam vec_t MW  = 14'h0040, RW  = 14'h0020, RD  = 14'h0010, M2R = 14'h0008;
  localparam vec_t PJ  = 14'h0004, PB  = 14'h0002, ILL = 14'h0001;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic alu_zero = 1'b0, mem_ready = 1'b0;
  logic [1:0] select_aluPerformance, pc_src;
  logic select_anotherAluSource, ext_op, ir_write, pc_en, mem_read, mem_write;
  logic reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0] retired_count;
  vec_t obs;

  mips_multicycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .select_aluPerformance(select_aluPerformance),
    .select_anotherAluSource(select_anotherAluSource),
    .ext_op(ext_op), .ir_write(ir_write), .pc_en(pc_en), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .illegal(illegal),
    .retired_count(retired_count)
  );

  assign obs = {select_aluPerformance, select_anotherAluSource, ext_op, ir_write, pc_en,
                mem_read, mem_write, reg_write, reg_dst, mem_to_reg, pc_src, illegal};

  always #5 clk = ~clk;

  int pass_n = 0, total_n = 0;
  logic [3:0] mcnt = '0;
  logic [5:0] pOp, pFn;
  vec_t exp_q[$], obs_q[$];
  logic [5:0] op_q[$], fn_q[$];
  logic rdy_q[$], zero_q[$], ret_q[$];
  logic [3:0] cobs_q[$], cexp_q[$];

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic void add(input vec_t e, input logic r, input logic z, input logic ret);
    exp_q.push_back(e); rdy_q.push_back(r); zero_q.push_back(z); ret_q.push_back(ret);
    op_q.push_back(pOp); fn_q.push_back(pFn);
  endfunction

  function automatic void clear();
    exp_q.delete(); obs_q.delete(); op_q.delete(); fn_q.delete();
    rdy_q.delete(); zero_q.delete(); ret_q.delete(); cobs_q.delete(); cexp_q.delete();
  endfunction

  // Expected trace of one instruction: fw fetch stalls, mw memory stalls.
  function automatic void plan(input logic [5:0] op, input logic [5:0] fn, input int fw,
                               input int mw, input logic z);
    vec_t a, m;
    pOp = op; pFn = fn;
    for (int i = 0; i < fw; i++) add(MR, 1'b0, rb(), 1'b0);
    add(MR | IRW | PCE, 1'b1, rb(), 1'b0);
    add('0, rb(), rb(), 1'b0);
    if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
      a = fn == 6'h23 ? SUB : '0;
      add(a, rb(), rb(), 1'b0);
      add(a | RW | RD, rb(), rb(), 1'b1);
    end else if (op == 6'h0d || op == 6'h0f) begin
      a = (op == 6'h0f ? LUI : OR_) | SRC;
      add(a, rb(), rb(), 1'b0);
      add(a | RW, rb(), rb(), 1'b1);
    end else if (op == 6'h23 || op == 6'h2b) begin
      a = SRC | EXT;
      m = op == 6'h23 ? MR : MW;
      add(a, rb(), rb(), 1'b0);
      for (int i = 0; i < mw; i++) add(a | m, 1'b0, rb(), 1'b0);
      add(a | m, 1'b1, rb(), op == 6'h2b);
      if (op == 6'h23) add(RW | M2R, rb(), rb(), 1'b1);
    end else if (op == 6'h04) begin
      add(SUB | EXT | PB | (z ? PCE : '0), rb(), z, 1'b1);
    end else if (op == 6'h02) begin
      add(PJ | PCE, rb(), rb(), 1'b1);
    end else begin
      for (int i = 0; i < 11; i++) add(ILL, rb(), rb(), 1'b0);
    end
  endfunction

  task automatic play(input int n);
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      @(negedge clk);
      opcode = op_q[i]; funct = fn_q[i]; mem_ready = rdy_q[i]; alu_zero = zero_q[i];
      #1;
      obs_q.push_back(obs); cobs_q.push_back(retired_count); cexp_q.push_back(mcnt);
      if (ret_q[i]) mcnt = mcnt + 4'd1;
    end
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0; mcnt = '0;
    #1;
    total_n++;
    if (obs !== '0 || retired_count !== 4'd0)
      $display("FAIL %s in-reset: got %h cnt %0d, want 0 cnt 0", name, obs, retired_count);
    else pass_n++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_n++;
    if (obs !== MR || retired_count !== 4'd0)
      $display("FAIL %s after-reset: got %h cnt %0d, want %h cnt 0", name, obs, retired_count, MR);
    else pass_n++;
  endtask

  task automatic test_reset();
    #2;
    total_n++;
    if (obs !== '0 || retired_count !== 4'd0)
      $display("FAIL reset: got %h cnt %0d, want 0 cnt 0", obs, retired_count);
    else pass_n++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_n++;
    if (obs !== MR) $display("FAIL reset_fetch: got %h, want %h", obs, MR);
    else pass_n++;
  endtask

  task automatic test_alu();
    plan(6'h00, 6'h21, 0, 0, 1'b0);
    plan(6'h0d, 6'h3f, 0, 0, 1'b0);
    plan(6'h00, 6'h23, 1, 0, 1'b0);
    plan(6'h0f, 6'h00, 2, 0, 1'b0);
    play(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      total_n++;
      if (obs_q[i] !== exp_q[i] || cobs_q[i] !== cexp_q[i])
        $display("FAIL alu cyc%0d: got %h cnt %0d, want %h cnt %0d", i, obs_q[i], cobs_q[i], exp_q[i], cexp_q[i]);
      else pass_n++;
    end
    clear();
  endtask

  task automatic test_mem();
    plan(6'h23, 6'h00, 0, 3, 1'b0);
    plan(6'h2b, 6'h00, 0, 0, 1'b0);
    plan(6'h2b, 6'h15, 2, 2, 1'b0);
    plan(6'h23, 6'h3c, 1, 0, 1'b0);
    play(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      total_n++;
      if (obs_q[i] !== exp_q[i] || cobs_q[i] !== cexp_q[i])
        $display("FAIL mem cyc%0d: got %h cnt %0d, want %h cnt %0d", i, obs_q[i], cobs_q[i], exp_q[i], cexp_q[i]);
      else pass_n++;
    end
    clear();
  endtask

  task automatic test_branch();
    plan(6'h04, 6'h00, 0, 0, 1'b1);
    plan(6'h04, 6'h00, 0, 0, 1'b0);
    plan(6'h02, 6'h00, 1, 0, 1'b0);
    plan(6'h04, 6'h21, 1, 0, 1'b1);
    play(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      total_n++;
      if (obs_q[i] !== exp_q[i] || cobs_q[i] !== cexp_q[i])
        $display("FAIL branch cyc%0d: got %h cnt %0d, want %h cnt %0d", i, obs_q[i], cobs_q[i], exp_q[i], cexp_q[i]);
      else pass_n++;
    end
    clear();
  endtask

  task automatic test_random();
    logic [5:0] ops[8] = '{6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02};
    logic [5:0] op, fn;
    int k;
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 7));
      op = ops[k];
      fn = k == 0 ? 6'h21 : k == 1 ? 6'h23 : 6'($urandom);
      plan(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb());
    end
    play(100000);
    for (int i = 0; i < obs_q.size(); i++) begin
      total_n++;
      if (obs_q[i] !== exp_q[i] || cobs_q[i] !== cexp_q[i])
        $display("FAIL random cyc%0d: got %h cnt %0d, want %h cnt %0d", i, obs_q[i], cobs_q[i], exp_q[i], cexp_q[i]);
      else pass_n++;
    end
    clear();
  endtask

  task automatic test_illegal();
    plan(6'h3f, 6'($urandom), 1, 0, 1'b0);
    play(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      total_n++;
      if (obs_q[i] !== exp_q[i] || cobs_q[i] !== cexp_q[i])
        $display("FAIL illegal_op cyc%0d: got %h cnt %0d, want %h cnt %0d", i, obs_q[i], cobs_q[i], exp_q[i], cexp_q[i]);
      else pass_n++;
    end
    clear();
    pulse_reset("illegal_op_reset");
    plan(6'h00, 6'h00, 0, 0, 1'b0);
    play(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      total_n++;
      if (obs_q[i] !== exp_q[i] || cobs_q[i] !== cexp_q[i])
        $display("FAIL illegal_funct cyc%0d: got %h cnt %0d, want %h cnt %0d", i, obs_q[i], cobs_q[i], exp_q[i], cexp_q[i]);
      else pass_n++;
    end
    clear();
    pulse_reset("illegal_funct_reset");
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 16; n++) plan(6'h02, 6'($urandom), 0, 0, 1'b0);
    play(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      total_n++;
      if (obs_q[i] !== exp_q[i] || cobs_q[i] !== cexp_q[i])
        $display("FAIL wrap cyc%0d: got %h cnt %0d, want %h cnt %0d", i, obs_q[i], cobs_q[i], exp_q[i], cexp_q[i]);
      else pass_n++;
    end
    clear();
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total_n++;
    if (retired_count !== 4'd0) $display("FAIL wrap_zero: got %0d, want 0", retired_count);
    else pass_n++;
  endtask

  task automatic test_abort();
    plan(6'h00, 6'h21, 0, 0, 1'b0);
    plan(6'h2b, 6'h00, 0, 6, 1'b0);
    play(8);
    for (int i = 0; i < obs_q.size(); i++) begin
      total_n++;
      if (obs_q[i] !== exp_q[i] || cobs_q[i] !== cexp_q[i])
        $display("FAIL abort cyc%0d: got %h cnt %0d, want %h cnt %0d", i, obs_q[i], cobs_q[i], exp_q[i], cexp_q[i]);
      else pass_n++;
    end
    clear();
    #2;
    rst_n = 1'b0;
    mcnt = '0;
    #1;
    total_n++;
    if (obs !== '0 || retired_count !== 4'd0)
      $display("FAIL abort_midwrite: got %h cnt %0d, want 0 cnt 0", obs, retired_count);
    else pass_n++;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    plan(6'h0d, 6'h00, 1, 0, 1'b0);
    play(1000);
    for (int i = 0; i < obs_q.size(); i++) begin
      total_n++;
      if (obs_q[i] !== exp_q[i] || cobs_q[i] !== cexp_q[i])
        $display("FAIL abort_resume cyc%0d: got %h cnt %0d, want %h cnt %0d", i, obs_q[i], cobs_q[i], exp_q[i], cexp_q[i]);
      else pass_n++;
    end
    clear();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_random();
    test_illegal();
    test_wrap();
    test_abort();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
